// File: rtl/ldl_sfifo_wrr_sched_pkg.sv
// Shared types and helpers for the LDL weighted round-robin FIFO scheduler.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, default credit width, rr_first() rotating pick.
package ldl_sched_pkg;

    localparam int LDL_CWIDTH_DFLT = 4;   // default weight / credit width
    localparam int LDL_MAX_N       = 16;  // largest queue count an LDL arbiter supports
    localparam int LDL_IDX_W       = 4;   // index width covering LDL_MAX_N

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    // First set bit of elig[n-1:0], searching from ptr+1 upward with wrap.
    // The loop walks from the farthest candidate (ptr itself) to the nearest
    // (ptr+1) so the nearest eligible index is the last one written.
    function automatic logic [LDL_IDX_W-1:0] rr_first(
        input logic [LDL_MAX_N-1:0] elig,
        input int                   n,
        input int                   ptr
    );
        logic [LDL_IDX_W-1:0] idx;
        idx = '0;
        for (int k = n; k >= 1; k--) begin
            int j;
            j = (ptr + k) % n;
            if (elig[j]) begin
                idx = LDL_IDX_W'(j);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ldl_sfifo_wrr_sched_if.sv
// Bundle between a bank of FWFT FIFOs, the scheduler and the shared consumer.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready on the consumer side; q_re strobes on the FIFO side.
// master = scheduler side; slave = FIFO bank / consumer / control side.
interface ldl_sfifo_wrr_sched_if
    import ldl_sched_pkg::*;
#(
    parameter int N      = 4,
    parameter int IWIDTH = $clog2(N),
    parameter int CWIDTH = LDL_CWIDTH_DFLT
);
    logic                en;
    logic [N-1:0]        q_empty;
    logic [N*CWIDTH-1:0] weight;
    logic [N-1:0]        q_re;
    logic                out_valid;
    logic                out_ready;
    logic [IWIDTH-1:0]   out_sel;
    logic [N-1:0]        grant;
    logic                busy;

    modport master (
        input  en, q_empty, weight, out_ready,
        output q_re, out_valid, out_sel, grant, busy
    );

    modport slave (
        output en, q_empty, weight, out_ready,
        input  q_re, out_valid, out_sel, grant, busy
    );
endinterface

// File: rtl/ldl_sfifo_wrr_sched_pick.sv
// Rotating priority pick: first set bit of elig searching from ptr+1 with wrap.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is set.
// Ports: elig (request vector), ptr (last winner), idx (winner), found (any request).
module ldl_rr_pick
    import ldl_sched_pkg::*;
#(
    parameter int N      = 4,
    parameter int IWIDTH = $clog2(N)
) (
    input  logic [N-1:0]      elig,
    input  logic [IWIDTH-1:0] ptr,
    output logic [IWIDTH-1:0] idx,
    output logic              found
);
    always_comb begin
        found = |elig;
        idx   = IWIDTH'(rr_first(LDL_MAX_N'(elig), N, int'(ptr)));
    end
endmodule

// File: rtl/ldl_sfifo_wrr_sched.sv
// Weighted round-robin read scheduler draining N FWFT FIFOs into one valid/ready channel.
// Latency: q_empty fall -> out_valid is 1 cycle from IDLE, 0 if that queue already holds the grant.
// Backpressure: out_ready low holds grant, out_sel and out_valid; q_re stays 0 until the beat moves.
// Ports: clk, rst_n (sync, active-low), sched (master modport: en, q_empty, weight, q_re,
//        out_valid, out_ready, out_sel, grant, busy).
module ldl_sfifo_wrr_sched
    import ldl_sched_pkg::*;
#(
    parameter int N      = 4,
    parameter int IWIDTH = $clog2(N),
    parameter int CWIDTH = LDL_CWIDTH_DFLT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ldl_sfifo_wrr_sched_if.master sched
);
    state_t              state;
    logic [IWIDTH-1:0]   sel_q;
    logic [IWIDTH-1:0]   rr_ptr;
    logic [CWIDTH-1:0]   credit;
    logic [N-1:0]        grant_q;

    logic [CWIDTH-1:0]   w_arr [N];
    logic [N-1:0]        elig;
    logic [IWIDTH-1:0]   pick_idx;
    logic                pick_found;
    logic                serve;
    logic                cur_empty;
    logic                out_valid;
    logic                xfer;
    logic                reload;
    logic                end_b;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_arr[i] = sched.weight[i*CWIDTH +: CWIDTH];
            elig[i]  = ~sched.q_empty[i] & (w_arr[i] != '0);
        end
    end

    ldl_rr_pick #(
        .N      (N),
        .IWIDTH (IWIDTH)
    ) u_pick (
        .elig  (elig),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign serve     = (state == SERVE);
    assign cur_empty = sched.q_empty[sel_q];
    // Gated by rst_n so a beat in flight when reset lands is never strobed out of the FIFO.
    assign out_valid = rst_n & serve & ~cur_empty;
    assign xfer      = out_valid & sched.out_ready;
    assign reload    = sched.en & pick_found;
    // Burst ends on the last credited beat, or when the granted queue has nothing to send.
    assign end_b     = serve & ((xfer & (credit == CWIDTH'(1))) | cur_empty);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= '0;
            rr_ptr  <= IWIDTH'(N - 1);
            credit  <= '0;
            grant_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (reload) begin
                        state   <= SERVE;
                        sel_q   <= pick_idx;
                        rr_ptr  <= pick_idx;
                        credit  <= w_arr[pick_idx];
                        grant_q <= N'(1) << pick_idx;
                    end
                end
                SERVE: begin
                    if (end_b) begin
                        // Back-to-back re-grant: the next burst starts on the same edge.
                        if (reload) begin
                            sel_q   <= pick_idx;
                            rr_ptr  <= pick_idx;
                            credit  <= w_arr[pick_idx];
                            grant_q <= N'(1) << pick_idx;
                        end else begin
                            state   <= IDLE;
                            grant_q <= '0;
                        end
                    end else if (xfer) begin
                        credit <= credit - CWIDTH'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign sched.out_valid = out_valid;
    assign sched.q_re      = xfer ? (N'(1) << sel_q) : '0;
    assign sched.out_sel   = sel_q;
    assign sched.grant     = grant_q;
    assign sched.busy      = serve;

endmodule

// File: tb/tb_ldl_sfifo_wrr_sched.sv
// Self-checking bench for ldl_sfifo_wrr_sched: FIFO bank model, WRR reference, scoreboard.
// Latency: n/a.
// Backpressure: out_ready driven directed and randomized.
module tb_ldl_sfifo_wrr_sched;
    localparam int N  = 4;
    localparam int CW = 4;

    typedef struct {
        int q;
        int seq;
    } exp_t;

    logic clk;
    logic rst_n;

    ldl_sfifo_wrr_sched_if #(.N(N), .CWIDTH(CW)) bus ();

    ldl_sfifo_wrr_sched #(.N(N), .CWIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sched (bus)
    );

    int   total = 0;
    int   bad   = 0;
    int   seq_ctr = 0;
    int   beats [N];
    int   wgt   [N];
    int   fifo  [N][$];   // bench FIFO bank contents (what the hardware FIFOs hold)
    int   mfifo [N][$];   // reference-model view of the same contents
    int   mptr;
    exp_t push_req [$];
    exp_t exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int q, input int n);
        for (int k = 0; k < n; k++) begin
            push_req.push_back('{q, seq_ctr});
            mfifo[q].push_back(seq_ctr);
            seq_ctr++;
        end
    endtask

    task automatic set_w(input int w0, input int w1, input int w2, input int w3);
        wgt[0] = w0; wgt[1] = w1; wgt[2] = w2; wgt[3] = w3;
        bus.weight = {CW'(w3), CW'(w2), CW'(w1), CW'(w0)};
    endtask

    // Reference WRR: bursts of min(weight, occupancy) from the next eligible queue after
    // the previous winner; queue contents are fixed while a round drains.
    task automatic model_run(input int max_bursts);
        for (int b = 0; b < max_bursts; b++) begin
            int pick;
            int nb;
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (mptr + k) % N;
                if (pick < 0 && mfifo[j].size() > 0 && wgt[j] != 0) pick = j;
            end
            if (pick < 0) break;
            nb = (wgt[pick] < mfifo[pick].size()) ? wgt[pick] : mfifo[pick].size();
            for (int k = 0; k < nb; k++) exp_q.push_back('{pick, mfifo[pick].pop_front()});
            mptr = pick;
        end
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!bus.busy && n < 50) begin tick(); n++; end
        total++;
        if (!bus.busy) begin bad++; $display("FAIL %s: busy never rose, actual=0 required=1", name); end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin tick(); n++; end
        total++;
        if (!bus.out_valid) begin bad++; $display("FAIL %s: out_valid never rose, actual=0 required=1", name); end
    endtask

    function automatic int beat_sum();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += beats[i];
        return s;
    endfunction

    task automatic drain(input string name, input bit rnd);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
            bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            n++;
        end
        bus.out_ready = 1'b1;
        total++;
        if (n >= 3000) begin
            bad++;
            $display("FAIL %s: drain timeout, pending actual=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
        chk({name, "_idle_busy"}, int'(bus.busy), 0);
    endtask

    // FIFO bank: pops on q_re sampled at the edge, then applies queued pushes and
    // publishes empty flags shortly after the edge (registered FIFO behaviour).
    initial begin
        logic [N-1:0] re;
        logic [N-1:0] emp;
        bus.q_empty = '1;
        forever begin
            @(posedge clk);
            re = bus.q_re;
            #1;
            for (int i = 0; i < N; i++) begin
                if (re[i]) begin
                    total++;
                    if (fifo[i].size() == 0) begin
                        bad++;
                        $display("FAIL read_on_empty q%0d: actual=empty required=non-empty", i);
                    end else begin
                        void'(fifo[i].pop_front());
                    end
                end
            end
            while (push_req.size() > 0) begin
                exp_t p;
                p = push_req.pop_front();
                fifo[p.q].push_back(p.seq);
            end
            for (int i = 0; i < N; i++) emp[i] = (fifo[i].size() == 0);
            bus.q_empty = emp;
        end
    end

    // Monitor: scoreboard pops on every transfer, plus handshake/grant rules each cycle.
    initial begin
        bit stall;
        int stall_sel;
        stall = 0;
        stall_sel = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 0;
            end else begin
                int sel;
                int req_re;
                sel = int'(bus.out_sel);
                if (bus.busy) chk("grant_onehot", int'(bus.grant), 1 << sel);
                else          chk("grant_idle", int'(bus.grant), 0);
                chk("valid_rule", int'(bus.out_valid), int'(bus.busy & ~bus.q_empty[sel]));
                req_re = (bus.out_valid & bus.out_ready) ? (1 << sel) : 0;
                chk("q_re_rule", int'(bus.q_re), req_re);
                if (stall) begin
                    chk("stall_valid", int'(bus.out_valid), 1);
                    chk("stall_sel", sel, stall_sel);
                end
                if (bus.out_valid && bus.out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_beat: actual=q%0d required=no beat", sel);
                    end else begin
                        exp_t e;
                        int dat;
                        e = exp_q.pop_front();
                        dat = (fifo[sel].size() > 0) ? fifo[sel][0] : -1;
                        if (sel != e.q || dat != e.seq) begin
                            bad++;
                            $display("FAIL beat_order: actual=q%0d/seq%0d required=q%0d/seq%0d",
                                     sel, dat, e.q, e.seq);
                        end
                    end
                    beats[sel]++;
                end
                stall = bus.out_valid & ~bus.out_ready;
                stall_sel = sel;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int bstart;
        int n;
        for (int i = 0; i < N; i++) beats[i] = 0;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.out_ready = 1'b0;
        set_w(0, 0, 0, 0);
        mptr = N - 1;

        // Reset, then equal weights of 2 drained back-to-back.
        set_w(2, 2, 2, 2);
        for (int i = 0; i < N; i++) push(i, 4);
        bus.en = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_q_re", int'(bus.q_re), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_out_sel", int'(bus.out_sel), 0);
        model_run(1000);
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_cycle_valid", int'(bus.out_valid), 0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("no_bubble_valid", int'(bus.out_valid), 1);
        end
        #2;
        drain("equal_w", 1'b0);

        // Weights {q3..q0} = {4,1,2,0} with a 5-cycle stall mid-run.
        bus.en = 1'b0;
        set_w(0, 2, 1, 4);
        push(0, 5); push(1, 3); push(2, 6); push(3, 12);
        tick(); tick();
        b0 = beats[0];
        model_run(1000);
        bus.en = 1'b1;
        bus.out_ready = 1'b1;
        bstart = beat_sum();
        n = 0;
        while (beat_sum() < bstart + 3 && n < 50) begin tick(); n++; end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid_hold", int'(bus.out_valid), 1);
            chk("bp_q_re_zero", int'(bus.q_re), 0);
        end
        drain("weighted", 1'b0);
        chk("q0_never_granted", beats[0], b0);

        // Early drain: queue 1 weight 8 but only 3 entries.
        bus.en = 1'b0;
        set_w(0, 8, 2, 2);
        push(1, 3); push(2, 4); push(3, 2);
        tick(); tick();
        model_run(1000);
        bus.en = 1'b1;
        drain("early_drain", 1'b1);

        // en dropped during a weight-3 burst: burst completes, then IDLE.
        bus.en = 1'b0;
        set_w(3, 3, 3, 3);
        push(1, 6); push(2, 6); push(3, 6);
        tick(); tick();
        model_run(1);
        bstart = beat_sum();
        bus.out_ready = 1'b1;
        bus.en = 1'b1;
        wait_busy("en_burst_start");
        bus.en = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 50) begin tick(); n++; end
        chk("en_low_busy", int'(bus.busy), 0);
        chk("en_low_beats", beat_sum() - bstart, 3);
        repeat (4) tick();
        chk("en_low_stays_idle", int'(bus.busy), 0);
        model_run(1000);
        bus.en = 1'b1;
        wait_busy("en_resume");
        chk("en_resume_sel", int'(bus.out_sel), exp_q.size() > 0 ? exp_q[0].q : -1);
        drain("en_resume", 1'b1);

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            bus.en = 1'b0;
            for (int i = 0; i < N; i++) begin
                wgt[i] = $urandom_range(0, 15);
                bus.weight[i*CW +: CW] = CW'(wgt[i]);
                push(i, $urandom_range(0, 9));
            end
            tick(); tick();
            model_run(1000);
            bus.en = 1'b1;
            drain("random", 1'b1);
        end

        // Reset while a beat is stalled.
        bus.en = 1'b0;
        set_w(2, 2, 2, 2);
        for (int i = 0; i < N; i++) push(i, 3);
        tick(); tick();
        model_run(1000);
        bus.out_ready = 1'b0;
        bus.en = 1'b1;
        wait_valid("rst_mid_valid");
        rst_n = 1'b0;
        #1;
        chk("rst_mid_q_re_now", int'(bus.q_re), 0);
        tick();
        chk("rst_mid_grant", int'(bus.grant), 0);
        chk("rst_mid_q_re", int'(bus.q_re), 0);
        chk("rst_mid_busy", int'(bus.busy), 0);
        exp_q.delete();
        for (int i = 0; i < N; i++) mfifo[i] = fifo[i];
        mptr = N - 1;
        model_run(1000);
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        wait_busy("rst_mid_regrant");
        chk("rst_mid_first_sel", int'(bus.out_sel), 0);
        drain("after_reset", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
